// File: rtl/bip_control.sv
`default_nettype none
// ============================================================================
// Module   : bip_control
// Purpose  : Control unit for a minimal accumulator processor (BIP).
//            Holds the program counter, runs an IDLE/RUN/HALT sequencer,
//            decodes the 5-bit opcode of the current instruction word into
//            datapath strobes, flags unknown opcodes and counts executed
//            instruction cycles.
// Ports    :
//   i_clock        - clock, all state changes on its rising edge
//   i_reset        - asynchronous active-low reset
//   i_Start        - start/restart program from address 0 (ignored in RUN)
//   i_Instruction  - program-memory word addressed by o_PC
//   o_PC           - program-memory address
//   o_SelA         - accumulator source: 00 data mem, 01 operand, 10 ALU
//   o_SelB         - ALU operand B: 0 data mem, 1 operand
//   o_WrAcc        - accumulator write strobe
//   o_Op           - ALU operation: 0 add, 1 subtract
//   o_WrRam        - data-memory write strobe
//   o_RdRam        - data-memory read strobe
//   o_Operand      - low operand field of i_Instruction
//   o_Halt         - high while halted
//   o_Illegal      - sticky: an unknown opcode was executed
//   o_Cycles       - saturating count of executed instruction cycles
// Revision : 1.0 - initial release
// ============================================================================
module bip_control #(
   parameter int NBITS_I  = 16,
   parameter int NBITS_O  = 11,
   parameter int NBITS_PC = 11,
   parameter int NBITS_C  = 16
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_Start,
   input  logic [NBITS_I-1:0]  i_Instruction,
   output logic [NBITS_PC-1:0] o_PC,
   output logic [1:0]          o_SelA,
   output logic                o_SelB,
   output logic                o_WrAcc,
   output logic                o_Op,
   output logic                o_WrRam,
   output logic                o_RdRam,
   output logic [NBITS_O-1:0]  o_Operand,
   output logic                o_Halt,
   output logic                o_Illegal,
   output logic [NBITS_C-1:0]  o_Cycles
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam logic [4:0] OP_HLT  = 5'b00000;
   localparam logic [4:0] OP_STO  = 5'b00001;
   localparam logic [4:0] OP_LD   = 5'b00010;
   localparam logic [4:0] OP_LDI  = 5'b00011;
   localparam logic [4:0] OP_ADD  = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_SUB  = 5'b00110;
   localparam logic [4:0] OP_SUBI = 5'b00111;

   localparam logic [NBITS_C-1:0] CYC_MAX = '1;

   state_t     state;
   logic [4:0] opcode;
   logic       illegal_op;
   logic       decode_en;

   assign opcode     = i_Instruction[NBITS_I-1 -: 5];
   assign o_Operand  = i_Instruction[NBITS_O-1:0];
   // Every opcode from 01000 upward is undefined.
   assign illegal_op = (opcode[4:3] != 2'b00);
   // Qualifying with the reset pin keeps the strobes low for the whole time
   // reset is held, independent of how the state register settles.
   assign decode_en  = (state == RUN) && i_reset;

   // Sequencer, PC, cycle counter and status flags
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state     <= IDLE;
         o_PC      <= '0;
         o_Cycles  <= '0;
         o_Illegal <= 1'b0;
         o_Halt    <= 1'b0;
      end else begin
         case (state)
            IDLE, HALT: begin
               if (i_Start) begin
                  state     <= RUN;
                  o_PC      <= '0;
                  o_Cycles  <= '0;
                  o_Illegal <= 1'b0;
                  o_Halt    <= 1'b0;
               end
            end
            RUN: begin
               // The HLT cycle itself is an executed cycle and is counted.
               if (o_Cycles != CYC_MAX) begin
                  o_Cycles <= o_Cycles + 1'b1;
               end
               if (opcode == OP_HLT) begin
                  state  <= HALT;
                  o_Halt <= 1'b1;
               end else begin
                  // Natural wrap at the top of the address space.
                  o_PC <= o_PC + 1'b1;
                  if (illegal_op) begin
                     o_Illegal <= 1'b1;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               o_Halt <= 1'b0;
            end
         endcase
      end
   end

   // Combinational opcode decode, active only while running
   always_comb begin
      o_WrAcc = 1'b0;
      o_SelA  = 2'b11;
      o_SelB  = 1'b0;
      o_Op    = 1'b0;
      o_WrRam = 1'b0;
      o_RdRam = 1'b0;
      if (decode_en) begin
         case (opcode)
            OP_STO: begin
               o_WrRam = 1'b1;
            end
            OP_LD: begin
               o_WrAcc = 1'b1;
               o_SelA  = 2'b00;
               o_RdRam = 1'b1;
            end
            OP_LDI: begin
               o_WrAcc = 1'b1;
               o_SelA  = 2'b01;
            end
            OP_ADD: begin
               o_WrAcc = 1'b1;
               o_SelA  = 2'b10;
               o_RdRam = 1'b1;
            end
            OP_ADDI: begin
               o_WrAcc = 1'b1;
               o_SelA  = 2'b10;
               o_SelB  = 1'b1;
            end
            OP_SUB: begin
               o_WrAcc = 1'b1;
               o_SelA  = 2'b10;
               o_Op    = 1'b1;
               o_RdRam = 1'b1;
            end
            OP_SUBI: begin
               o_WrAcc = 1'b1;
               o_SelA  = 2'b10;
               o_SelB  = 1'b1;
               o_Op    = 1'b1;
            end
            default: begin
               // HLT and undefined opcodes drive no strobes.
               o_WrAcc = 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bip_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_bip_control
// Purpose  : Self-checking bench for bip_control. Two instances run side by
//            side: one with default widths and one with a 3-bit PC and a
//            2-bit cycle counter, each tracked by a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bip_control;

   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_HALT = 2;

   // {WrAcc, SelA[1:0], SelB, Op, WrRam, RdRam} for opcodes 0..7
   localparam logic [6:0] DEC_TAB [0:7] = '{
      7'b0110000, 7'b0110010, 7'b1000001, 7'b1010000,
      7'b1100001, 7'b1101000, 7'b1100101, 7'b1101100 };
   localparam logic [6:0] DEC_IDLE = 7'b0110000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start0 = 1'b0, start1 = 1'b0;
   logic [15:0] instr0 = '0, instr1 = '0;

   logic [10:0] pc0;
   logic [2:0]  pc1;
   logic [1:0]  sela0, sela1;
   logic        selb0, selb1, wracc0, wracc1, op0, op1;
   logic        wrram0, wrram1, rdram0, rdram1;
   logic [10:0] opd0, opd1;
   logic        halt0, halt1, ill0, ill1;
   logic [15:0] cyc0;
   logic [1:0]  cyc1;

   always #5 clk = ~clk;

   bip_control dut0 (
      .i_clock(clk), .i_reset(rst_n), .i_Start(start0), .i_Instruction(instr0),
      .o_PC(pc0), .o_SelA(sela0), .o_SelB(selb0), .o_WrAcc(wracc0), .o_Op(op0),
      .o_WrRam(wrram0), .o_RdRam(rdram0), .o_Operand(opd0), .o_Halt(halt0),
      .o_Illegal(ill0), .o_Cycles(cyc0));

   bip_control #(.NBITS_PC(3), .NBITS_C(2)) dut1 (
      .i_clock(clk), .i_reset(rst_n), .i_Start(start1), .i_Instruction(instr1),
      .o_PC(pc1), .o_SelA(sela1), .o_SelB(selb1), .o_WrAcc(wracc1), .o_Op(op1),
      .o_WrRam(wrram1), .o_RdRam(rdram1), .o_Operand(opd1), .o_Halt(halt1),
      .o_Illegal(ill1), .o_Cycles(cyc1));

   logic [15:0] prog0 [0:2047];
   logic [15:0] prog1 [0:7];

   // Behavioural model, one entry per instance
   int m_state [2];
   int m_pc    [2];
   int m_cyc   [2];
   int m_ill   [2];
   int pc_size [2] = '{2048, 8};
   int cyc_max [2] = '{65535, 3};

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mk(input int op, input int operand);
      logic [4:0]  o;
      logic [10:0] a;
      o = op[4:0];
      a = operand[10:0];
      return {o, a};
   endfunction

   function automatic logic [15:0] rand_word();
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 3) != 0) w[15:11] = 5'($urandom_range(0, 7));
      return w;
   endfunction

   function automatic logic [6:0] exp_dec(input int st, input logic [15:0] ins);
      int op;
      op = int'(ins[15:11]);
      if (st != S_RUN || op >= 8) return DEC_IDLE;
      return DEC_TAB[op];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_state[k] = S_IDLE; m_pc[k] = 0; m_cyc[k] = 0; m_ill[k] = 0;
      end
   endtask

   task automatic model_edge(input int k, input logic st, input logic [15:0] ins);
      int op;
      op = int'(ins[15:11]);
      if (m_state[k] == S_RUN) begin
         if (m_cyc[k] < cyc_max[k]) m_cyc[k]++;
         if (op == 0) m_state[k] = S_HALT;
         else begin
            m_pc[k] = (m_pc[k] + 1) % pc_size[k];
            if (op >= 8) m_ill[k] = 1;
         end
      end else if (st) begin
         m_state[k] = S_RUN; m_pc[k] = 0; m_cyc[k] = 0; m_ill[k] = 0;
      end
   endtask

   task automatic check_all();
      chk("dut0.pc",      32'(pc0),    m_pc[0]);
      chk("dut0.cycles",  32'(cyc0),   m_cyc[0]);
      chk("dut0.halt",    32'(halt0),  (m_state[0] == S_HALT) ? 1 : 0);
      chk("dut0.illegal", 32'(ill0),   m_ill[0]);
      chk("dut0.decode",  32'({wracc0, sela0, selb0, op0, wrram0, rdram0}),
          32'(exp_dec(m_state[0], instr0)));
      chk("dut0.operand", 32'(opd0),   32'(instr0[10:0]));
      chk("dut1.pc",      32'(pc1),    m_pc[1]);
      chk("dut1.cycles",  32'(cyc1),   m_cyc[1]);
      chk("dut1.halt",    32'(halt1),  (m_state[1] == S_HALT) ? 1 : 0);
      chk("dut1.illegal", 32'(ill1),   m_ill[1]);
      chk("dut1.decode",  32'({wracc1, sela1, selb1, op1, wrram1, rdram1}),
          32'(exp_dec(m_state[1], instr1)));
   endtask

   task automatic drive(input logic s0, input logic s1);
      start0 = s0;
      start1 = s1;
      instr0 = (m_state[0] == S_RUN) ? prog0[m_pc[0]] : rand_word();
      instr1 = (m_state[1] == S_RUN) ? prog1[m_pc[1]] : rand_word();
   endtask

   // One clock: drive at the falling edge, check, then advance the model.
   task automatic step(input logic s0, input logic s1);
      @(negedge clk);
      drive(s0, s1);
      #1;
      check_all();
      @(posedge clk);
      model_edge(0, start0, instr0);
      model_edge(1, start1, instr1);
   endtask

   // Reset pulse dropped mid-cycle, held across one rising edge.
   task automatic reset_pulse();
      @(negedge clk);
      drive(1'b0, 1'b0);
      #1;
      check_all();
      #1;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("rst.wrram", 32'(wrram0), 0);
      @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      for (int i = 0; i < 2048; i++) prog0[i] = mk(0, 0);
      for (int i = 0; i < 8; i++)    prog1[i] = mk(3, i);

      // Reset state while reset is held
      #2;
      check_all();
      chk("rst.sela", 32'(sela0), 3);
      @(negedge clk);
      #2;
      rst_n = 1'b1;

      // Remain idle without a start pulse
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

      // LDI 5, ADDI 3, STO 2, HLT
      prog0[0] = mk(3, 5); prog0[1] = mk(5, 3); prog0[2] = mk(1, 2); prog0[3] = mk(0, 0);
      step(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
      #1;
      chk("prog1.halt", 32'(halt0), 1);
      chk("prog1.pc", 32'(pc0), 3);
      chk("prog1.cycles", 32'(cyc0), 4);
      step(1'b0, 1'b0);

      // LD 7, SUB 7, HLT; start pulse also exercised while running
      prog0[0] = mk(2, 7); prog0[1] = mk(6, 7); prog0[2] = mk(0, 0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      #1;
      chk("prog2.cycles", 32'(cyc0), 3);

      // Undefined opcode then HLT; restart clears the flag
      prog0[0] = mk(10, 0); prog0[1] = mk(0, 0);
      step(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      #1;
      chk("prog3.illegal", 32'(ill0), 1);
      step(1'b1, 1'b0);
      #1;
      chk("prog3.restart_ill", 32'(ill0), 0);
      chk("prog3.restart_pc", 32'(pc0), 0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      // Narrow instance: PC wrap and cycle saturation on an LDI loop
      step(1'b0, 1'b1);
      for (int i = 1; i <= 10; i++) begin
         step(1'b0, 1'b0);
         #1;
         if (i == 8) chk("wrap.pc", 32'(pc1), 0);
      end
      chk("sat.cycles", 32'(cyc1), 3);

      // Reset mid-program while the STO at PC=2 is on the bus
      prog0[0] = mk(3, 1); prog0[1] = mk(3, 2); prog0[2] = mk(1, 4); prog0[3] = mk(0, 0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      reset_pulse();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

      // Randomized programs, start pulses and occasional resets
      for (int i = 0; i < 2048; i++) prog0[i] = rand_word();
      for (int i = 0; i < 8; i++)    prog1[i] = rand_word();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 149) == 0) reset_pulse();
         else step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute time bound
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
